// File: rtl/piano_note_scan_display.sv
// Note/octave front end for an electronic piano: synchronises keys and octave buttons,
// priority-encodes the note, and time-multiplexes letter + octave onto a 7-seg panel.
// Optional octave-button debounce is compiled in with `define OCT_DEBOUNCE_EN.
module piano_note_scan_display #(
  parameter int NUM_KEYS   = 7,
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int OCT_MIN    = 1,
  parameter int OCT_MAX    = 7,
  parameter int OCT_RESET  = 4,
  parameter int DEB_CYC    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_KEYS-1:0]   key,
  input  logic                  up,
  input  logic                  down,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic [3:0]            octave,
  output logic                  note_valid
);

  localparam int CNT_W     = $clog2(SCAN_DIV);
  localparam int IDX_W     = $clog2(NUM_DIGITS);
  localparam int NOTE_KEYS = (NUM_KEYS < 7) ? NUM_KEYS : 7;

  genvar gi;

  // Letter glyphs for C,D,E,F,G,A,B in key order; D and B use lower-case shapes.
  function automatic logic [6:0] letter_seg(input logic [2:0] idx);
    logic [6:0] s;
    case (idx)
      3'd0:    s = 7'b0111001;
      3'd1:    s = 7'b1011110;
      3'd2:    s = 7'b1111001;
      3'd3:    s = 7'b1110001;
      3'd4:    s = 7'b0111101;
      3'd5:    s = 7'b1110111;
      3'd6:    s = 7'b1111100;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  function automatic logic [6:0] digit_seg(input logic [3:0] val);
    logic [6:0] s;
    case (val)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // ---------------- input synchronisers ----------------
  logic [NUM_KEYS-1:0] key_s1_q, key_s1_d, key_s2_q, key_s2_d;
  logic [1:0]          btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;  // bit0 = up, bit1 = down

  always_comb begin
    key_s1_d = key;
    key_s2_d = key_s1_q;
    btn_s1_d = {down, up};
    btn_s2_d = btn_s1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1_q <= '0;
      key_s2_q <= '0;
      btn_s1_q <= '0;
      btn_s2_q <= '0;
    end else begin
      key_s1_q <= key_s1_d;
      key_s2_q <= key_s2_d;
      btn_s1_q <= btn_s1_d;
      btn_s2_q <= btn_s2_d;
    end
  end

  // ---------------- optional button debounce ----------------
  logic [1:0] btn_clean;

`ifdef OCT_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEB_CYC + 1);

  for (gi = 0; gi < 2; gi++) begin : g_deb
    logic             deb_q, deb_d;
    logic [DEB_W-1:0] cnt_q, cnt_d;

    // The counter only runs while the input disagrees with the stable value,
    // so any return to the old level throws away the partial count.
    always_comb begin
      deb_d = deb_q;
      cnt_d = '0;
      if (btn_s2_q[gi] != deb_q) begin
        if (cnt_q == DEB_W'(DEB_CYC - 1)) begin
          deb_d = btn_s2_q[gi];
        end else begin
          cnt_d = cnt_q + DEB_W'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        deb_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        deb_q <= deb_d;
        cnt_q <= cnt_d;
      end
    end

    assign btn_clean[gi] = deb_q;
  end
`else
  assign btn_clean = btn_s2_q;
`endif

  // ---------------- octave counter ----------------
  logic [1:0] btn_prev_q, btn_prev_d;
  logic [1:0] btn_rise;
  logic [3:0] octave_q, octave_d;

  assign btn_rise = btn_clean & ~btn_prev_q;

  always_comb begin
    btn_prev_d = btn_clean;
    octave_d   = octave_q;
    // Coincident up/down edges cancel; limits saturate rather than wrap.
    if (btn_rise[0] && !btn_rise[1] && (octave_q < 4'(OCT_MAX))) begin
      octave_d = octave_q + 4'd1;
    end else if (btn_rise[1] && !btn_rise[0] && (octave_q > 4'(OCT_MIN))) begin
      octave_d = octave_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_prev_q <= '0;
      octave_q   <= 4'(OCT_RESET);
    end else begin
      btn_prev_q <= btn_prev_d;
      octave_q   <= octave_d;
    end
  end

  // ---------------- note priority encoder ----------------
  logic       note_hit;
  logic [2:0] note_idx;

  always_comb begin
    note_hit = 1'b0;
    note_idx = 3'd0;
    for (int i = NOTE_KEYS - 1; i >= 0; i--) begin
      if (key_s2_q[i]) begin
        note_hit = 1'b1;
        note_idx = 3'(i);
      end
    end
  end

  // ---------------- scan sequencer ----------------
  logic [CNT_W-1:0]      scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]      dig_idx_q, dig_idx_d;
  logic [NUM_DIGITS-1:0] dig_onehot;
  logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d;
  logic [6:0]            seg_q, seg_d;

  for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_onehot
    assign dig_onehot[gi] = (dig_idx_q == IDX_W'(gi));
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + CNT_W'(1);
    dig_idx_d  = dig_idx_q;
    if (scan_cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      dig_idx_d  = (dig_idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : dig_idx_q + IDX_W'(1);
    end
  end

  // Enable and segment data are both derived from the same index, so they
  // always change on the same edge.
  always_comb begin
    dig_en_d = dig_onehot;
    seg_d    = 7'b0000000;
    if (dig_idx_q == IDX_W'(0)) begin
      seg_d = note_hit ? letter_seg(note_idx) : 7'b0000000;
    end else if (dig_idx_q == IDX_W'(1)) begin
      seg_d = digit_seg(octave_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q <= '0;
      dig_idx_q  <= '0;
      dig_en_q   <= '0;
      seg_q      <= '0;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      dig_idx_q  <= dig_idx_d;
      dig_en_q   <= dig_en_d;
      seg_q      <= seg_d;
    end
  end

  assign seg        = seg_q;
  assign dig_en     = dig_en_q;
  assign octave     = octave_q;
  assign note_valid = note_hit;

endmodule
